// File: rtl/pipe_cla_sub_pkg.sv
// ============================================================================
// Module   : pipe_cla_sub_pkg
// Desc     : Shared ALU op encodings, group width and helpers for pipe_cla_sub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_cla_sub_pkg;

    localparam int c_grp_w = 4;
    localparam int c_op_w  = 2;

    typedef enum logic [c_op_w-1:0] {
        OP_SUB  = 2'd0,
        OP_SLT  = 2'd1,
        OP_SLTU = 2'd2,
        OP_SEQ  = 2'd3
    } op_e;

    // Compare-type ops always subtract with no incoming borrow.
    function automatic logic eff_borrow(input op_e op, input logic bin);
        return (op == OP_SUB) ? bin : 1'b0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sub_group4.sv
// ============================================================================
// Module   : sub_group4
// Desc     : 4-bit borrow-lookahead group: group generate/propagate and the
//            local difference for a given group borrow-in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_group4
    import pipe_cla_sub_pkg::*;
(
    input  logic [c_grp_w-1:0] a,
    input  logic [c_grp_w-1:0] b,
    input  logic               bin,
    output logic               g,
    output logic               p,
    output logic [c_grp_w-1:0] d
);

    logic [c_grp_w-1:0] w_bg;
    logic [c_grp_w-1:0] w_bp;
    logic [c_grp_w-1:0] w_bb;

    // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
    assign w_bg = ~a & b;
    assign w_bp = ~(a ^ b);

    assign w_bb[0] = bin;
    assign w_bb[1] = w_bg[0] | (w_bp[0] & bin);
    assign w_bb[2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & bin);
    assign w_bb[3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0])
                   | (w_bp[2] & w_bp[1] & w_bp[0] & bin);

    assign g = w_bg[3] | (w_bp[3] & w_bg[2]) | (w_bp[3] & w_bp[2] & w_bg[1])
             | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);
    assign p = &w_bp;
    assign d = a ^ b ^ w_bb;

endmodule

`default_nettype wire

// File: rtl/pipe_cla_sub.sv
// ============================================================================
// Module   : pipe_cla_sub
// Desc     : Two-stage valid/ready pipelined borrow-lookahead subtractor with
//            SUB / SLT / SLTU / SEQ result selection and compare flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_cla_sub
    import pipe_cla_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NGRP  = WIDTH / c_grp_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             bout,
    output logic             zero,
    output logic             lt_s,
    output logic             lt_u
);

    localparam int c_nsg = (NGRP + c_grp_w - 1) / c_grp_w;
    localparam int c_pad = c_nsg * c_grp_w;

    // ---------------- handshake ----------------
    logic w_s1_adv;
    logic w_s2_adv;
    logic r_s1_valid;
    logic r_s2_valid;

    assign w_s2_adv = !r_s2_valid | out_ready;
    assign w_s1_adv = !r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    // ---------------- stage 1: group generate / propagate ----------------
    logic [NGRP-1:0]  w_s1_g;
    logic [NGRP-1:0]  w_s1_p;
    logic [WIDTH-1:0] w_s1_d_unused;

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_s1_grp
            sub_group4 u_grp (
                .a   (a[gi*c_grp_w +: c_grp_w]),
                .b   (b[gi*c_grp_w +: c_grp_w]),
                .bin (1'b0),
                .g   (w_s1_g[gi]),
                .p   (w_s1_p[gi]),
                .d   (w_s1_d_unused[gi*c_grp_w +: c_grp_w])
            );
        end
    endgenerate

    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    op_e              r_s1_op;
    logic             r_s1_cin;
    logic [NGRP-1:0]  r_s1_g;
    logic [NGRP-1:0]  r_s1_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_SUB;
            r_s1_cin   <= 1'b0;
            r_s1_g     <= '0;
            r_s1_p     <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a   <= a;
                r_s1_b   <= b;
                r_s1_op  <= op_e'(op);
                r_s1_cin <= eff_borrow(op_e'(op), bin);
                r_s1_g   <= w_s1_g;
                r_s1_p   <= w_s1_p;
            end
        end
    end

    // ---------------- stage 2: two-level borrow lookahead ----------------
    // Padding groups generate nothing and propagate, so the top supergroup
    // borrow is the overall borrow-out.
    logic [c_pad-1:0] w_gx;
    logic [c_pad-1:0] w_px;
    logic [c_nsg-1:0] w_sg_g;
    logic [c_nsg-1:0] w_sg_p;
    logic [c_nsg:0]   w_sg_b;
    logic [NGRP-1:0]  w_grp_b;

    always_comb begin
        w_gx             = '0;
        w_px             = '1;
        w_gx[NGRP-1:0]   = r_s1_g;
        w_px[NGRP-1:0]   = r_s1_p;
    end

    always_comb begin
        w_sg_g = '0;
        w_sg_p = '0;
        for (int s = 0; s < c_nsg; s++) begin
            w_sg_p[s] = &w_px[s*c_grp_w +: c_grp_w];
            w_sg_g[s] = w_gx[s*c_grp_w+3]
                      | (w_px[s*c_grp_w+3] & w_gx[s*c_grp_w+2])
                      | (w_px[s*c_grp_w+3] & w_px[s*c_grp_w+2] & w_gx[s*c_grp_w+1])
                      | (w_px[s*c_grp_w+3] & w_px[s*c_grp_w+2] & w_px[s*c_grp_w+1]
                         & w_gx[s*c_grp_w]);
        end
    end

    always_comb begin
        logic t;
        logic term;
        t         = 1'b0;
        term      = 1'b0;
        w_sg_b    = '0;
        w_sg_b[0] = r_s1_cin;
        for (int s = 1; s <= c_nsg; s++) begin
            term = r_s1_cin;
            for (int k = 0; k < s; k++) term = term & w_sg_p[k];
            t = term;
            for (int j = 0; j < s; j++) begin
                term = w_sg_g[j];
                for (int k = j + 1; k < s; k++) term = term & w_sg_p[k];
                t = t | term;
            end
            w_sg_b[s] = t;
        end
    end

    always_comb begin
        logic t;
        logic term;
        int   base;
        t       = 1'b0;
        term    = 1'b0;
        base    = 0;
        w_grp_b = '0;
        for (int gi = 0; gi < NGRP; gi++) begin
            base = (gi / c_grp_w) * c_grp_w;
            term = w_sg_b[gi / c_grp_w];
            for (int k = base; k < gi; k++) term = term & w_px[k];
            t = term;
            for (int j = base; j < gi; j++) begin
                term = w_gx[j];
                for (int k = j + 1; k < gi; k++) term = term & w_px[k];
                t = t | term;
            end
            w_grp_b[gi] = t;
        end
    end

    logic [WIDTH-1:0] w_diff;
    logic [NGRP-1:0]  w_s2_g_unused;
    logic [NGRP-1:0]  w_s2_p_unused;

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_s2_grp
            sub_group4 u_grp (
                .a   (r_s1_a[gi*c_grp_w +: c_grp_w]),
                .b   (r_s1_b[gi*c_grp_w +: c_grp_w]),
                .bin (w_grp_b[gi]),
                .g   (w_s2_g_unused[gi]),
                .p   (w_s2_p_unused[gi]),
                .d   (w_diff[gi*c_grp_w +: c_grp_w])
            );
        end
    endgenerate

    logic             w_bout;
    logic             w_ovf;
    logic             w_lts;
    logic             w_zero;
    logic [WIDTH-1:0] w_res;

    assign w_bout = w_sg_b[c_nsg];
    assign w_ovf  = (r_s1_a[WIDTH-1] ^ r_s1_b[WIDTH-1]) & (r_s1_a[WIDTH-1] ^ w_diff[WIDTH-1]);
    assign w_lts  = w_diff[WIDTH-1] ^ w_ovf;
    assign w_zero = ~|w_diff;

    always_comb begin
        w_res = '0;
        case (r_s1_op)
            OP_SUB:  w_res    = w_diff;
            OP_SLT:  w_res[0] = w_lts;
            OP_SLTU: w_res[0] = w_bout;
            OP_SEQ:  w_res[0] = w_zero;
            default: w_res    = '0;
        endcase
    end

    logic [WIDTH-1:0] r_result;
    logic             r_bout;
    logic             r_zero;
    logic             r_lt_s;
    logic             r_lt_u;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_bout     <= 1'b0;
            r_zero     <= 1'b0;
            r_lt_s     <= 1'b0;
            r_lt_u     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_bout   <= w_bout;
                r_zero   <= w_zero;
                r_lt_s   <= w_lts;
                r_lt_u   <= w_bout;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign bout      = r_bout;
    assign zero      = r_zero;
    assign lt_s      = r_lt_s;
    assign lt_u      = r_lt_u;

endmodule

`default_nettype wire

// File: tb/tb_pipe_cla_sub.sv
// ============================================================================
// Module   : tb_pipe_cla_sub
// Desc     : Self-checking bench for pipe_cla_sub: directed vectors, stall and
//            reset sequences, and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_cla_sub;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         bout;
    logic         zero;
    logic         lt_s;
    logic         lt_u;

    always #5 clk = ~clk;

    pipe_cla_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .bout      (bout),
        .zero      (zero),
        .lt_s      (lt_s),
        .lt_u      (lt_u)
    );

    // flags are packed as {bout, zero, lt_s, lt_u}
    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] res;
        logic [3:0]   flg;
    } vec_t;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_out    = 0;
    exp_t         sb_q[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] held_res;
    logic [3:0]   held_flg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    // Plain-arithmetic reference: wide integer subtraction and comparisons.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic bi);
        exp_t   e;
        longint ux   = longint'({32'b0, x});
        longint uy   = longint'({32'b0, y});
        longint sx   = longint'($signed(x));
        longint sy   = longint'($signed(y));
        longint bb   = (o == 2'd0 && bi) ? 64'd1 : 64'd0;
        logic [W-1:0] d = W'(ux - uy - bb);
        logic lu = (ux < uy + bb);
        logic ls = (sx < sy + bb);
        logic z  = (d == '0);
        e.flg = {lu, z, ls, lu};
        case (o)
            2'd0:    e.res = d;
            2'd1:    e.res = {{(W-1){1'b0}}, ls};
            2'd2:    e.res = {{(W-1){1'b0}}, lu};
            default: e.res = {{(W-1){1'b0}}, z};
        endcase
        return e;
    endfunction

    // One clock: drive at negedge, observe handshakes just after, score outputs.
    task automatic tick(input logic iv, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic bi, input logic ordy,
                        output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        op        = o;
        a         = x;
        b         = y;
        bin       = bi;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", 64'(result), 64'(held_res));
            chk("hold_flags", 64'({bout, zero, lt_s, lt_u}), 64'(held_flg));
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_result", 64'(result), 64'(e.res));
                chk("sb_flags", 64'({bout, zero, lt_s, lt_u}), 64'(e.flg));
                n_out++;
            end
        end
        prev_stall = out_valid && !out_ready;
        held_res   = result;
        held_flg   = {bout, zero, lt_s, lt_u};
        if (acc) sb_q.push_back(model(o, x, y, bi));
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom % 8)
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[12];
        logic         acc;
        logic         iv;
        logic         ordy;
        logic         saw_drop;
        int           sent;
        int           base;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0; op = 2'd0;

        vecs[0]  = '{2'd0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 4'b0000};
        vecs[1]  = '{2'd0, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b1011};
        vecs[2]  = '{2'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h0000_0001, 4'b0010};
        vecs[3]  = '{2'd2, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0010};
        vecs[4]  = '{2'd3, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0001, 4'b0100};
        vecs[5]  = '{2'd0, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 4'b1011};
        vecs[6]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 4'b0100};
        vecs[7]  = '{2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1001};
        vecs[8]  = '{2'd2, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h0000_0001, 4'b1001};
        vecs[9]  = '{2'd3, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0000, 4'b1011};
        vecs[10] = '{2'd0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b1011};
        vecs[11] = '{2'd1, 32'h0000_0003, 32'h0000_0003, 1'b1, 32'h0000_0000, 4'b0100};

        // Reset state
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'({bout, zero, lt_s, lt_u}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors with exact 2-cycle latency (first one on first edge after reset)
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].bin, 1'b1, acc);
            chk($sformatf("vec%0d_accept", i), 64'(acc), 64'd1);
            tick(1'b0, 2'd0, '0, '0, 1'b0, 1'b1, acc);
            chk($sformatf("vec%0d_lat1_valid", i), 64'(out_valid), 64'd0);
            tick(1'b0, 2'd0, '0, '0, 1'b0, 1'b1, acc);
            chk($sformatf("vec%0d_lat2_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].res));
            chk($sformatf("vec%0d_flags", i), 64'({bout, zero, lt_s, lt_u}), 64'(vecs[i].flg));
        end

        // Eight back-to-back SUBs with out_ready low for cycles 3-5
        sent = 0; saw_drop = 1'b0; base = n_out;
        for (int cyc = 0; cyc < 40 && (sent < 8 || n_out - base < 8); cyc++) begin
            iv   = (sent < 8);
            ordy = !(cyc >= 3 && cyc <= 5);
            tick(iv, 2'd0, W'(32'h1000 * (sent + 1) + 7), W'(sent * 3), sent[0], ordy, acc);
            if (acc) sent++;
            if (iv && !acc) saw_drop = 1'b1;
        end
        chk("stream_in_ready_drop", 64'(saw_drop), 64'd1);
        chk("stream_count", 64'(n_out - base), 64'd8);
        chk("stream_q_empty", 64'(sb_q.size()), 64'd0);

        // Asynchronous reset with both stages full
        for (int i = 0; i < 3; i++) tick(1'b1, 2'd0, W'($urandom), W'($urandom), 1'b0, 1'b0, acc);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        #1 rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_result", 64'(result), 64'd0);
        sb_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 2'd0, '0, '0, 1'b0, 1'b1, acc);
            chk("no_stale_out", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with random backpressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ra = rand_operand();
            rb = ($urandom % 6 == 0) ? ra : rand_operand();
            tick(($urandom % 10) < 7, 2'($urandom), ra, rb, 1'($urandom),
                 ($urandom % 10) < 6, acc);
        end
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1'b0, 2'd0, '0, '0, 1'b0, 1'b1, acc);
        chk("drain_q_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
